spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI responder (slave) for the SPI master in this design; runs on the system clock.
//  Oversamples SCLK/SS/MOSI, shifts MSB-first frames of DATA_WIDTH bits, returns rx bytes and drives MISO.
//  Mode 0..3 via cpol/cpha. Sits between the SPI pins and the local byte-stream logic.
// PARAMETERS
//  DATA_WIDTH   8  bits per frame
//  SYNC_STAGES  2  flops in each input synchronizer (min 2)
// PORTS
//  clk       in   1           system clock; all logic on posedge clk
//  reset     in   1           synchronous, active-high reset
//  SCLK      in   1           SPI clock from master (async to clk)
//  MOSI      in   1           serial data from master
//  SS        in   1           slave select, active low
//  MISO      out  1           serial data to master
//  cpol      in   1           clock idle level
//  cpha      in   1           0: sample on leading edge, 1: sample on trailing edge
//  tx_data   in   DATA_WIDTH  byte to send next
//  tx_valid  in   1           tx_data valid
//  tx_ready  out  1           tx buffer empty; write occurs on tx_valid&&tx_ready
//  rx_data   out  DATA_WIDTH  last completed received byte
//  rx_valid  out  1           1-clk pulse: rx_data updated
// BEHAVIOUR
//  - Reset: MISO=0, tx_ready=1, rx_data=0, rx_valid=0, tx buffer empty, state=WAIT_HIGH.
//  - SCLK, SS, MOSI pass SYNC_STAGES flops; SCLK/SS edges detected on synced values. clk >= 8x SCLK.
//  - Leading edge = rise if cpol=0 else fall. Sample edge = leading if cpha=0 else trailing; the other edge is the shift edge.
//  - cpol/cpha captured on SS fall; held for the whole SS-low period.
//  - FSM: WAIT_HIGH -> IDLE when synced SS=1 (prevents starting mid-frame after reset).
//    IDLE -> ACTIVE on SS fall: tx_shift <= tx buffer (0 if empty), buffer emptied, bit_cnt=0, started=0.
//    ACTIVE -> IDLE on SS rise, any bit_cnt.
//  - Sample edge: rx_shift <= {rx_shift[DATA_WIDTH-2:0], MOSI_sync}; bit_cnt++; started=1.
//    On the DATA_WIDTH-th sample: rx_data <= completed byte; rx_valid pulses 1 clk; bit_cnt=0.
//  - Shift edge, only when started=1: if bit_cnt==0, reload tx_shift from buffer (0 if empty), else shift left.
//    CPHA=1: the first leading edge of a frame does nothing.
//  - MISO = tx_shift[MSB] while ACTIVE; 0 otherwise.
//  - Back-to-back frames under continuous SS low are supported.
//  - Latency: rx_valid <= SYNC_STAGES+2 clk after the physical sample edge.
//  - tx write and reload in the same clk: reload sees the pre-write buffer; the write then fills the buffer.
//  - SS rise mid-frame: partial rx discarded, no rx_valid, loaded tx byte counts as consumed.
//  - reset mid-frame: abort as above; no frame starts until SS goes high then low again.
//  - bit_cnt wraps at DATA_WIDTH only; SCLK edges while IDLE/WAIT_HIGH are ignored.
// CONFIGURATION
//  SPI_SLAVE_STATUS_EN defined: adds outputs tx_underrun and frame_abort (1-clk pulses, reset 0).
//    tx_underrun pulses when a load/reload finds the buffer empty.
//    frame_abort pulses when SS rises with 0 < bit_cnt < DATA_WIDTH.
//  Undefined: ports absent, behaviour otherwise identical.
// STRUCTURE
//  spi_pkg: state enum {WAIT_HIGH, IDLE, ACTIVE}, SPI mode typedef, DEFAULT_DATA_WIDTH.
//  Sub-module spi_sync_edge: N-stage synchronizer + rise/fall pulse.
//    Instanced for SCLK and SS; MOSI uses its synced output.
// TESTING
//  - Mode 0, tx 0xA5, master sends 0x3C -> master reads 0xA5; rx_data=0x3C, one rx_valid pulse.
//  - Modes 1/2/3, same bytes -> identical results in every mode.
//  - Two frames, SS held low, tx 0x12 then 0x34 written in time -> MISO 0x12, 0x34; two rx_valid pulses.
//  - Empty tx buffer at SS fall -> MISO 0x00; tx_underrun pulses (STATUS_EN).
//  - SS rise after 3 bits -> no rx_valid; frame_abort pulses; next full frame receives correctly.
//  - Reset while SS low mid-frame, SS kept low -> no activity until SS high then low; next frame OK.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI responder (spi_slave).
//   spi_state_e        : responder state (WAIT_HIGH, IDLE, ACTIVE)
//   spi_mode_t         : captured SPI mode (cpol, cpha)
//   DEFAULT_DATA_WIDTH : default frame length in bits
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      WAIT_HIGH = 2'd0,
      IDLE      = 2'd1,
      ACTIVE    = 2'd2
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // SPI sample edge is the leading edge for CPHA=0 and the trailing edge otherwise.
   function automatic logic sample_on_leading(input spi_mode_t m);
      return !m.cpha;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// N-stage synchronizer for one asynchronous input, followed by rise/fall
// pulse detection on the synchronized value.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high reset
//   i_async  in  asynchronous input
//   o_sync   out synchronized level
//   o_rise   out 1-clk pulse on a synchronized 0->1 transition
//   o_fall   out 1-clk pulse on a synchronized 1->0 transition
// Parameters:
//   STAGES    synchronizer depth (>= 2)
//   RESET_VAL level the chain assumes while in reset
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_chain;
   logic              r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= {STAGES{RESET_VAL}};
         r_prev  <= RESET_VAL;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
         r_prev  <= r_chain[STAGES-1];
      end
   end

   assign o_sync = r_chain[STAGES-1];
   assign o_rise = r_chain[STAGES-1] & ~r_prev;
   assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder running on the system clock. SCLK, SS and MOSI are
// oversampled through synchronizers; MSB-first frames of DATA_WIDTH bits are
// received into rx_data and transmitted on MISO from a one-entry tx buffer.
// SPI modes 0..3 are selected by cpol/cpha, captured when SS falls.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   SCLK, MOSI, SS     SPI pins from the master (SS active low)
//   MISO               serial data to the master (0 when not selected)
//   cpol, cpha         SPI mode for the next frame
//   tx_data/valid/ready  one-entry tx buffer write (write on valid && ready)
//   rx_data/rx_valid   last completed received word, 1-clk update strobe
//   tx_underrun        (SPI_SLAVE_STATUS_EN) load/reload found buffer empty
//   frame_abort        (SPI_SLAVE_STATUS_EN) SS rose in the middle of a frame
// Configuration macro: SPI_SLAVE_STATUS_EN adds the two status pulse outputs.
// -----------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SCLK,
   input  logic                  MOSI,
   input  logic                  SS,
   output logic                  MISO,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid
`ifdef SPI_SLAVE_STATUS_EN
   ,
   output logic                  tx_underrun,
   output logic                  frame_abort
`endif
);

   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CNT_W  = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
   logic w_ss_sync, w_ss_rise, w_ss_fall;

   spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .reset   (reset),
      .i_async (SCLK),
      .o_sync  (w_sclk_sync),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   // SS chain resets to "selected" so that a reset taken while SS is low
   // never looks like a fresh SS fall; WAIT_HIGH then holds until SS is high.
   spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_ss (
      .clk     (clk),
      .reset   (reset),
      .i_async (SS),
      .o_sync  (w_ss_sync),
      .o_rise  (w_ss_rise),
      .o_fall  (w_ss_fall)
   );

   // MOSI uses the same depth as SCLK so the sampled bit lines up with the edge.
   logic [SYNC_N-1:0] r_mosi_sync;
   always_ff @(posedge clk) begin
      if (reset) r_mosi_sync <= '0;
      else       r_mosi_sync <= {r_mosi_sync[SYNC_N-2:0], MOSI};
   end
   logic w_mosi;
   assign w_mosi = r_mosi_sync[SYNC_N-1];

   spi_state_e            r_state;
   spi_mode_t             r_mode;
   logic [DATA_WIDTH-1:0] r_tx_buf;
   logic                  r_tx_full;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic                  r_rx_valid;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic                  r_started;

   // An SCLK edge is leading when it moves SCLK away from its idle level.
   logic w_sclk_edge, w_lead, w_trail, w_sample, w_shift;
   assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
   assign w_lead      = w_sclk_edge & (w_sclk_sync != r_mode.cpol);
   assign w_trail     = w_sclk_edge & (w_sclk_sync == r_mode.cpol);
   assign w_sample    = sample_on_leading(r_mode) ? w_lead  : w_trail;
   assign w_shift     = sample_on_leading(r_mode) ? w_trail : w_lead;

   logic w_start, w_run, w_reload, w_load, w_tx_wr;
   assign w_start  = (r_state == IDLE) & w_ss_fall;
   assign w_run    = (r_state == ACTIVE) & ~w_ss_rise;
   // A shift edge with bit_cnt==0 sits on a frame boundary: fetch the next word.
   // Before the first sample of a frame (started=0) shift edges are ignored,
   // which drops the opening leading edge in CPHA=1.
   assign w_reload = w_run & w_shift & r_started & (r_bit_cnt == '0);
   assign w_load   = w_start | w_reload;
   assign w_tx_wr  = tx_valid & ~r_tx_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= WAIT_HIGH;
         r_mode     <= '0;
         r_tx_buf   <= '0;
         r_tx_full  <= 1'b0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_bit_cnt  <= '0;
         r_started  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            WAIT_HIGH: begin
               if (w_ss_sync) r_state <= IDLE;
            end
            IDLE: begin
               if (w_ss_fall) begin
                  r_state   <= ACTIVE;
                  r_mode    <= spi_mode_t'{cpol, cpha};
                  r_bit_cnt <= '0;
                  r_started <= 1'b0;
               end
            end
            ACTIVE: begin
               if (w_ss_rise) begin
                  r_state <= IDLE;
               end else if (w_sample) begin
                  r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                  r_started  <= 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_rx_data  <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                     r_rx_valid <= 1'b1;
                     r_bit_cnt  <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else if (w_shift && r_started && (r_bit_cnt != '0)) begin
                  r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
               end
            end
            default: r_state <= WAIT_HIGH;
         endcase

         // A load consumes the buffer; a write in the same clock refills it
         // afterwards, so the load always sees the pre-write contents.
         if (w_load) begin
            r_tx_shift <= r_tx_full ? r_tx_buf : '0;
            r_tx_full  <= 1'b0;
         end
         if (w_tx_wr) begin
            r_tx_buf  <= tx_data;
            r_tx_full <= 1'b1;
         end
      end
   end

   assign MISO     = (r_state == ACTIVE) ? r_tx_shift[DATA_WIDTH-1] : 1'b0;
   assign tx_ready = ~r_tx_full;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_STATUS_EN
   logic r_tx_underrun;
   logic r_frame_abort;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_underrun <= 1'b0;
         r_frame_abort <= 1'b0;
      end else begin
         r_tx_underrun <= w_load & ~r_tx_full;
         r_frame_abort <= (r_state == ACTIVE) & w_ss_rise & (r_bit_cnt != '0);
      end
   end

   assign tx_underrun = r_tx_underrun;
   assign frame_abort = r_frame_abort;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Bench for spi_slave: a behavioural SPI master drives frames in all four
// modes; a word-level model of the tx buffer predicts the MISO bytes, and an
// rx scoreboard queue is checked by a monitor on every rx_valid pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave;

   localparam int CLK_P = 10;
   localparam int HALF  = 80;   // SCLK half period = 8 system clocks

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       SCLK = 1'b0;
   logic       MOSI = 1'b0;
   logic       SS = 1'b1;
   logic       MISO;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
`ifdef SPI_SLAVE_STATUS_EN
   logic       tx_underrun;
   logic       frame_abort;
`endif

   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .SS          (SS),
      .MISO        (MISO),
      .cpol        (cpol),
      .cpha        (cpha),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid)
`ifdef SPI_SLAVE_STATUS_EN
      ,
      .tx_underrun (tx_underrun),
      .frame_abort (frame_abort)
`endif
   );

   always #(CLK_P/2) clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_buf  = 8'h00;
   logic       m_full = 1'b0;
   int exp_under = 0;
   int exp_abort = 0;
   int exp_rx_cnt = 0;
   int act_rx_cnt = 0;
   int act_under = 0;
   int act_abort = 0;
   logic [7:0] exp_rx_q[$];

   // The responder takes a word from the buffer (or 0 when empty) and empties it.
   function automatic logic [7:0] take();
      logic [7:0] v;
      v = m_full ? m_buf : 8'h00;
      if (!m_full) exp_under++;
      m_full = 1'b0;
      return v;
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rx_valid) begin
         act_rx_cnt++;
         if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no rx_valid (t=%0t)", rx_data, $time);
         end else begin
            check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_q.pop_front()});
         end
      end
`ifdef SPI_SLAVE_STATUS_EN
      if (tx_underrun) act_under++;
      if (frame_abort) act_abort++;
`endif
   end

   initial begin
      #(800_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] b_mosi [4];
   bit         b_wr   [4];
   logic [7:0] b_wrb  [4];

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      while (!tx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("tx_ready_before_write", {31'h0, tx_ready}, {31'h0, !m_full});
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      m_buf  = b;
      m_full = 1'b1;
   endtask

   task automatic frame(input logic [7:0] mo, input int nbits, input int wr_at,
                        input logic [7:0] wr_b, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            MOSI = mo[7-i];
            #HALF; SCLK = ~SCLK;
            mi = {mi[6:0], MISO};
            #HALF; SCLK = ~SCLK;
         end else begin
            #HALF; SCLK = ~SCLK;
            MOSI = mo[7-i];
            #HALF; SCLK = ~SCLK;
            mi = {mi[6:0], MISO};
         end
         if (i == wr_at) write_tx(wr_b);
      end
   endtask

   task automatic set_mode(input logic p, input logic h);
      @(negedge clk);
      cpol = p;
      cpha = h;
      SCLK = p;
      wait_neg(6);
   endtask

   // n frames back to back under one SS-low period
   task automatic burst(input logic p, input logic h, input int n);
      logic [7:0] mi;
      logic [7:0] exp_mi;
      set_mode(p, h);
      SS = 1'b0;
      exp_mi = take();
      for (int k = 0; k < n; k++) begin
         if (k > 0 && h) exp_mi = take();
         exp_rx_q.push_back(b_mosi[k]);
         exp_rx_cnt++;
         frame(b_mosi[k], 8, b_wr[k] ? 2 : -1, b_wrb[k], mi);
         check("miso_byte", {24'h0, mi}, {24'h0, exp_mi});
         if (!h) exp_mi = take();
      end
      #HALF; SS = 1'b1;
      #(4*HALF);
   endtask

   task automatic abort_frame(input logic p, input logic h, input logic [7:0] mo, input int nbits);
      logic [7:0] mi;
      set_mode(p, h);
      SS = 1'b0;
      void'(take());
      frame(mo, nbits, -1, 8'h00, mi);
      #HALF; SS = 1'b1;
      exp_abort++;
      #(4*HALF);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] mi;
      wait_neg(5);
      reset = 1'b0;
      @(negedge clk);
      check("reset_miso",     {31'h0, MISO},     32'h0);
      check("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
      check("reset_rx_data",  {24'h0, rx_data},  32'h0);
      check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
      wait_neg(6);

      // one frame per mode: tx 0xA5, master sends 0x3C
      for (int m = 0; m < 4; m++) begin
         write_tx(8'hA5);
         b_mosi[0] = 8'h3C; b_wr[0] = 1'b0; b_wrb[0] = 8'h00;
         burst(m[1], m[0], 1);
      end

      // two frames under continuous SS low, second tx word written mid-frame
      for (int m = 0; m < 4; m += 3) begin
         write_tx(8'h12);
         b_mosi[0] = 8'h5A; b_wr[0] = 1'b1; b_wrb[0] = 8'h34;
         b_mosi[1] = 8'hC3; b_wr[1] = 1'b0; b_wrb[1] = 8'h00;
         burst(m[1], m[0], 2);
      end

      // empty buffer at SS fall
      b_mosi[0] = 8'h81; b_wr[0] = 1'b0;
      burst(1'b0, 1'b1, 1);

      // SS rise after 3 bits, then a normal frame
      write_tx(8'hE7);
      abort_frame(1'b0, 1'b0, 8'hF0, 3);
      write_tx(8'h69);
      b_mosi[0] = 8'h96; b_wr[0] = 1'b0;
      burst(1'b0, 1'b0, 1);

      // reset in mid-frame with SS held low
      write_tx(8'h77);
      set_mode(1'b0, 1'b0);
      SS = 1'b0;
      void'(take());
      frame(8'hFF, 3, -1, 8'h00, mi);
      @(negedge clk);
      reset = 1'b1;
      wait_neg(2);
      reset = 1'b0;
      m_full = 1'b0;
      frame(8'hAA, 5, -1, 8'h00, mi);
      check("miso_after_reset",     {31'h0, MISO},     32'h0);
      check("tx_ready_after_reset", {31'h0, tx_ready}, 32'h1);
      #HALF; SS = 1'b1;
      #(4*HALF);
      write_tx(8'hB4);
      b_mosi[0] = 8'h2D; b_wr[0] = 1'b0;
      burst(1'b0, 1'b0, 1);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         logic p, h;
         int   n;
         p = 1'($urandom_range(1));
         h = 1'($urandom_range(1));
         if ($urandom_range(4) == 0) begin
            if (!m_full && $urandom_range(1) == 1) write_tx(8'($urandom));
            abort_frame(p, h, 8'($urandom), $urandom_range(7, 1));
         end else begin
            n = $urandom_range(3, 1);
            if (!m_full && $urandom_range(3) != 0) write_tx(8'($urandom));
            for (int k = 0; k < n; k++) begin
               b_mosi[k] = 8'($urandom);
               b_wr[k]   = (k < n - 1) && ($urandom_range(3) != 0);
               b_wrb[k]  = 8'($urandom);
            end
            burst(p, h, n);
         end
      end

      wait_neg(20);
      check("rx_queue_drained", exp_rx_q.size(), 32'h0);
      check("rx_valid_count",   act_rx_cnt, exp_rx_cnt);
      check("tx_ready_final",   {31'h0, tx_ready}, {31'h0, !m_full});
`ifdef SPI_SLAVE_STATUS_EN
      check("tx_underrun_count", act_under, exp_under);
      check("frame_abort_count", act_abort, exp_abort);
`endif
      $display("Model events: %0d underruns, %0d aborts, %0d status pulses seen",
               exp_under, exp_abort, act_under + act_abort);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
